// File: rtl/sa_skew_feeder_pkg.sv
// sa_pkg: shared array sizes, feeder FSM encoding and drain length for sa_skew_feeder
package sa_pkg;
  localparam int N = 4;
  localparam int DW = 16;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction
  localparam int DRAIN_CYCLES = drain_cycles(N);
endpackage

// File: rtl/sa_skew_feeder_if.sv
// sa_skew_feeder_if: K-step beat stream (in_valid/in_ready/in_last, in_a/in_b N lanes of DW bits); master drives beats, slave returns in_ready
interface sa_skew_feeder_if import sa_pkg::*; #(
  parameter int N = sa_pkg::N,
  parameter int DW = sa_pkg::DW
);
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [N*DW-1:0] in_a;
  logic [N*DW-1:0] in_b;
  modport master(output in_valid, in_last, in_a, in_b, input in_ready);
  modport slave(input in_valid, in_last, in_a, in_b, output in_ready);
endinterface

// File: rtl/sa_skew_feeder_skew_line.sv
// skew_line: DEPTH-stage zero-reset shift chain (clk, rst, d_i W bits in, q_o W bits out after DEPTH edges)
module skew_line #(
  parameter int DEPTH = 1,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] sr_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '{default: '0};
    else begin
      sr_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
    end
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: diagonal-skew feeder for an NxN systolic array
// Ports: clk, rst (sync, active-high); s = beat stream slave; a_row_o/b_col_o skewed edge data;
// valid_o/clear_o per-lane strobes; done_o tile complete; busy_o streaming or draining.
// Optional macro SA_SKEW_FEEDER_KMAX_CHECK_EN adds kmax_err_o and forces last on the K_MAX-th beat.
module sa_skew_feeder import sa_pkg::*; #(
  parameter int N = sa_pkg::N,
  parameter int DW = sa_pkg::DW,
  parameter int K_MAX = 256
) (
  input  logic            clk,
  input  logic            rst,
  sa_skew_feeder_if.slave s,
  output logic [N*DW-1:0] a_row_o,
  output logic [N*DW-1:0] b_col_o,
  output logic [N-1:0]    valid_o,
  output logic [N-1:0]    clear_o,
  output logic            done_o,
  output logic            busy_o
`ifdef SA_SKEW_FEEDER_KMAX_CHECK_EN
  ,
  output logic            kmax_err_o
`endif
);
  localparam int CW = $clog2(drain_cycles(N));
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          acc, first, last;
  assign s.in_ready = state_q != DRAIN;
  assign acc = s.in_valid && s.in_ready;
  assign first = state_q == IDLE || state_q == DONE;
`ifdef SA_SKEW_FEEDER_KMAX_CHECK_EN
  localparam int BW = $clog2(K_MAX + 1);
  logic [BW-1:0] beats_q, beat_n;
  logic          err_q, force_last;
  assign beat_n = first ? BW'(1) : beats_q + 1'b1;
  assign force_last = beat_n == BW'(K_MAX);
  assign last = s.in_last || force_last;
  assign kmax_err_o = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q <= '0;
      err_q <= 1'b0;
    end else if (acc) begin
      beats_q <= beat_n;
      err_q <= (!first && err_q) || (force_last && !s.in_last);
    end
  end
`else
  assign last = s.in_last;
`endif
  // The drain counter runs 2N-2..0 so done_o rises 2N-1 edges after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else if (acc) begin
      state_q <= last ? DRAIN : STREAM;
      cnt_q <= CW'(drain_cycles(N) - 1);
    end else if (state_q == DRAIN) begin
      state_q <= cnt_q == '0 ? DONE : DRAIN;
      cnt_q <= cnt_q - 1'b1;
    end
  end
  assign done_o = state_q == DONE;
  assign busy_o = state_q == STREAM || state_q == DRAIN;
  // Lane i carries {clear, valid, b, a}; bubbles inject all zeros.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(.DEPTH(i + 1), .W(2 * DW + 2)) u_line (
      .clk(clk),
      .rst(rst),
      .d_i(acc ? {first, 1'b1, s.in_b[i*DW +: DW], s.in_a[i*DW +: DW]} : '0),
      .q_o({clear_o[i], valid_o[i], b_col_o[i*DW +: DW], a_row_o[i*DW +: DW]})
    );
  end
endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
- Upstream stage of the 4x4 systolic array: accepts one K-step per beat (N A-row elements plus N B-column elements) over a valid/ready stream.
- Applies the diagonal input skew, so lane i is delayed i cycles, and drives the array's west (A) and north (B) edges.
- Generates the per-lane valid and clear strobes, and the tile-wide done level that gates PE result outputs.
- One tile is a sequence of beats terminated by in_last.

Parameters:
- N, 4, array dimension: number of A lanes and B lanes.
- DW, 16, signed element width.
- K_MAX, 256, maximum beats per tile; used only by the optional feature.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  feeder can accept a beat
- in_last  in  1  final beat of the tile
- in_a  in  N*DW  A elements; lane i at [i*DW +: DW], for row i
- in_b  in  N*DW  B elements; lane j at [j*DW +: DW], for column j
- a_row_o  out  N*DW  skewed A to west edge PE(i,0)
- b_col_o  out  N*DW  skewed B to north edge PE(0,j)
- valid_o  out  N  per-lane skewed valid
- clear_o  out  N  per-lane skewed clear; marks the first beat of a tile
- done_o  out  1  tile complete; all PE accumulators final
- busy_o  out  1  state != IDLE and state != DONE

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high; it overrides everything.
- Reset values: state=IDLE; all skew registers, a_row_o, b_col_o, valid_o, clear_o and done_o are 0; in_ready=1.
- Accept rule: a beat is accepted on an edge where in_valid && in_ready.
- Skew, lane i: the output equals the accepted beat i cycles after the acceptance edge.
  - Lane 0 output is registered; it is valid in the cycle after acceptance.
  - Lane i uses an i-deep shift chain behind that register.
- Valid and clear travel with the data through the same chain.
- Bubbles: a cycle with no accepted beat inserts data=0, valid=0 and clear=0 into every chain.
- clear: asserted (with valid) on the first accepted beat after IDLE or DONE.
- FSM states:
  - IDLE: in_ready=1. An accepted beat goes to STREAM, or straight to DRAIN if in_last=1.
  - STREAM: in_ready=1. An accepted beat with in_last=1 goes to DRAIN. A beat without in_last stays in STREAM.
  - DRAIN: in_ready=0. A counter loads 2N-2 on entry and decrements each cycle. At 0 the FSM goes to DONE.
  - DONE: done_o=1 and in_ready=1. An accepted beat clears done_o on that edge, enters STREAM or DRAIN per in_last, and carries clear.
- Drain latency: done_o first reads 1 in the cycle after edge E+2N-1, where E is the last-beat acceptance edge (cycle after edge E+7 for N=4). This covers the last lane-3 beat reaching PE(N-1,N-1) and being accumulated.
- Arithmetic: no arithmetic on data; pure delay. Widths are passed unchanged.
- Reset mid-operation: any state returns to IDLE, chains flush to zero, done_o=0. The partial tile is discarded.
- A beat never enters a chain while in_ready=0, whatever the value of in_valid.

Optional Feature:
- Macro: SA_SKEW_FEEDER_KMAX_CHECK_EN.
- When defined:
  - A beat counter is added.
  - If the K_MAX-th beat is accepted without in_last, it is treated as last and the FSM enters DRAIN.
  - Sticky output kmax_err_o (1 bit) is set; it is cleared by rst or by the next tile's first beat.
- When undefined: no counter, no kmax_err_o port, and tiles are unbounded.

Decomposition:
- Shared package sa_pkg:
  - N and DW defaults.
  - FSM state encoding (IDLE, STREAM, DRAIN, DONE).
  - Constant DRAIN_CYCLES = 2*N-1.
- Sub-module skew_line: one lane with a parameter DEPTH, carrying a {clear, valid, data} shift chain. It is instantiated N times with DEPTH=i+1.

Test Plan:
- Reset then a single beat: in_a lanes = 1,2,3,4 with in_last. Lane i shows value i+1 with valid=1 and clear=1 exactly i+1 cycles after acceptance. done_o reads 1 in the cycle after edge E+7.
- Four back-to-back beats (K=4), A=B=identity columns, feeding a 4x4 pe array. done_o rises in the cycle after edge 10, beats accepted on edges 0..3. PE(i,j) acc_o = C[i][j] = identity.
- Same tile with in_valid toggling 1,0,1,0. Bubbles appear as valid=0, data=0. Final PE results are identical to the gapless run. The done_o delay is measured from the last beat.
- In DONE, present a new tile. done_o drops on the acceptance edge, and clear_o is set on its first beat in every lane. New results exclude the prior tile (acc value 5 becomes 2 for a 1x2 product).
- Assert rst during DRAIN at counter=3. Next cycle: all outputs 0, in_ready=1, and done_o never rises.
- SA_SKEW_FEEDER_KMAX_CHECK_EN with K_MAX=4: five beats without in_last. The 4th beat forces DRAIN, kmax_err_o=1, and in_ready=0 on the 5th.
